bcd_timer_core: RTL and testbench

//  Parametrised BCD stopwatch / countdown timer core for the iCEBreaker display designs.
//  - Counts up or down in packed BCD at a prescaled tick rate.
//  - Supports start, stop, clear, preset load and a timed lap-hold snapshot.
//  - Drives seven_seg_ctrl instances directly from disp_value; button decode and debounce sit upstream.

---
 rtl/bcd_timer_core.sv | 91 +++++++++
 tb/tb_bcd_timer_core.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: packed-BCD stopwatch/countdown core with prescaled tick,
// preset load and a timed lap-hold snapshot for the display path.
module bcd_timer_core #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 120000,
    parameter int LAP_HOLD = 200
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                stop,
    input  logic                lap,
    input  logic                clear,
    input  logic                load,
    input  logic                down,
    input  logic [4*DIGITS-1:0] preset,
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] disp_value,
    output logic                running,
    output logic                lap_active,
    output logic                tick,
    output logic                wrap,
    output logic                done
);
    localparam int W  = 4*DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV-1);

    logic [PW-1:0] presc_q;
    logic [W-1:0]  count_q, count_d, snap_q, inc, dec, clamp;
    logic [7:0]    lap_q, lap_d;
    logic          tick_q, running_q, run_d, wrap_q, wrap_d, done_q, done_d;
    logic          carry, borrow, step_up, step_dn, dec_zero;

    always_comb begin
        inc    = count_q;
        dec    = count_q;
        clamp  = preset;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            inc[4*i+:4]   = carry ? (count_q[4*i+:4] == 4'd9 ? 4'd0 : count_q[4*i+:4] + 4'd1) : count_q[4*i+:4];
            carry         = carry && count_q[4*i+:4] == 4'd9;
            dec[4*i+:4]   = borrow ? (count_q[4*i+:4] == 4'd0 ? 4'd9 : count_q[4*i+:4] - 4'd1) : count_q[4*i+:4];
            borrow        = borrow && count_q[4*i+:4] == 4'd0;
            clamp[4*i+:4] = preset[4*i+:4] > 4'd9 ? 4'd9 : preset[4*i+:4];
        end
    end

    // load and clear pre-empt a coinciding step, so neither pulse fires then
    assign step_up  = tick_q && running_q && !down && !clear && !load;
    assign step_dn  = tick_q && running_q && down && !clear && !load;
    assign dec_zero = count_q <= W'(1);
    assign wrap_d   = step_up && carry;
    assign done_d   = step_dn && dec_zero;
    assign count_d  = clear ? '0 : load ? clamp : step_up ? inc : step_dn ? (dec_zero ? '0 : dec) : count_q;
    assign run_d    = (clear || stop) ? 1'b0 :
                      start ? (running_q || !(down && count_q == '0)) :
                      done_d ? 1'b0 : running_q;
    assign lap_d    = clear ? 8'd0 : lap ? 8'(LAP_HOLD) : (tick_q && lap_q != 8'd0) ? lap_q - 8'd1 : lap_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            count_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            snap_q    <= '0;
            lap_q     <= 8'd0;
        end else begin
            presc_q   <= presc_q == LAST ? '0 : presc_q + PW'(1);
            tick_q    <= presc_q == LAST;
            count_q   <= count_d;
            running_q <= run_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            snap_q    <= lap ? count_q : snap_q;
            lap_q     <= lap_d;
        end
    end

    assign count      = count_q;
    assign lap_active = lap_q != 8'd0;
    assign disp_value = lap_active ? snap_q : count_q;
    assign running    = running_q;
    assign tick       = tick_q;
    assign wrap       = wrap_q;
    assign done       = done_q;
endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core: randomized and directed checks of bcd_timer_core
// against a decimal-integer reference model (DIGITS=4, TICK_DIV=4, LAP_HOLD=3).
module tb_bcd_timer_core;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        start = 0, stop = 0, lap = 0, clear = 0, load = 0, down = 0;
    logic [15:0] preset = '0;
    logic [15:0] count, disp_value;
    logic        running, lap_active, tick, wrap, done;
    int          n_cmp = 0, n_bad = 0;
    int          m_cnt, m_snap, m_lt, m_pre;
    bit          m_run, m_tick, m_wrap, m_done;

    bcd_timer_core #(.DIGITS(4), .TICK_DIV(4), .LAP_HOLD(3)) dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .lap(lap), .clear(clear),
        .load(load), .down(down), .preset(preset), .count(count), .disp_value(disp_value),
        .running(running), .lap_active(lap_active), .tick(tick), .wrap(wrap), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] bcd(int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clampv(logic [15:0] p);
        int r = 0, m = 1;
        for (int i = 0; i < 4; i++) begin
            r += (p[4*i+:4] > 4'd9 ? 9 : int'(p[4*i+:4])) * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic logic [36:0] exp_vec();
        return {bcd(m_cnt), (m_lt != 0) ? bcd(m_snap) : bcd(m_cnt), m_run, m_lt != 0, m_tick, m_wrap, m_done};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {count, disp_value, running, lap_active, tick, wrap, done};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_snap = 0; m_lt = 0; m_pre = 0;
        m_run = 0; m_tick = 0; m_wrap = 0; m_done = 0;
    endtask

    // advance the reference one clock using the inputs currently applied
    task automatic cycle();
        int ncnt = m_cnt, nsnap = m_snap, nlt;
        bit nrun = m_run, nw = 0, nd = 0, step = m_tick && m_run;
        if (clear) ncnt = 0;
        else if (load) ncnt = clampv(preset);
        else if (step && !down) begin
            ncnt = (m_cnt + 1) % 10000;
            nw = (m_cnt == 9999);
        end else if (step) begin
            ncnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            nd = (ncnt == 0);
        end
        if (clear || stop) nrun = 0;
        else if (start) nrun = (down && m_cnt == 0) ? m_run : 1'b1;
        else if (nd) nrun = 0;
        if (lap) nsnap = m_cnt;
        nlt = clear ? 0 : lap ? 3 : (m_tick && m_lt > 0) ? m_lt - 1 : m_lt;
        @(posedge CLK);
        m_tick = (m_pre == 3);
        m_pre = (m_pre + 1) % 4;
        m_cnt = ncnt; m_snap = nsnap; m_lt = nlt; m_run = nrun; m_wrap = nw; m_done = nd;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        model_reset();
        n_cmp++;
        if (dut_vec() !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h exp %h", dut_vec(), 37'd0);
        end
        RST = 1'b0;
    endtask

    task automatic test_count_up();
        int last = -1, cyc = 0;
        start = 1;
        cycle();
        start = 0;
        while (m_cnt < 12 && cyc < 200) begin
            cycle();
            cyc++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL count_up cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== 4) begin
                        n_bad++;
                        $display("FAIL tick_period got %0d exp 4", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_cmp++;
        if (count !== 16'h0012 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL count_up_final got %h/%b exp 0012/1", count, running);
        end
    endtask

    task automatic test_wrap();
        int cyc = 0, nwrap = 0;
        load = 1; preset = 16'h9998;
        cycle();
        load = 0; start = 1;
        cycle();
        start = 0;
        while ((m_cnt != 0 || nwrap == 0) && cyc < 100) begin
            cycle();
            cyc++;
            if (wrap === 1'b1) nwrap++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_run cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
        end
        repeat (3) begin
            cycle();
            if (wrap === 1'b1) nwrap++;
        end
        n_cmp++;
        if (nwrap !== 1 || count !== 16'h0000 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_once got wraps=%0d count=%h run=%b exp 1/0000/1", nwrap, count, running);
        end
    endtask

    task automatic test_down();
        int cyc = 0, ndone = 0;
        clear = 1;
        cycle();
        clear = 0; load = 1; preset = 16'h0100; down = 1;
        cycle();
        load = 0; start = 1;
        cycle();
        start = 0;
        while (m_cnt != 99 && cyc < 50) begin
            cycle();
            cyc++;
        end
        n_cmp++;
        if (count !== 16'h0099) begin
            n_bad++;
            $display("FAIL down_first got %h exp 0099", count);
        end
        cyc = 0;
        while (m_run && cyc < 600) begin
            cycle();
            cyc++;
            if (done === 1'b1) ndone++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL down_run cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
        end
        repeat (8) begin
            cycle();
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone !== 1 || count !== 16'h0000 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL down_done got dones=%0d count=%h run=%b exp 1/0000/0", ndone, count, running);
        end
        start = 1;
        cycle();
        start = 0;
        cycle();
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL start_at_zero got %b exp 0", running);
        end
        down = 0;
    endtask

    task automatic test_lap();
        int cyc = 0;
        clear = 1;
        cycle();
        clear = 0; start = 1;
        cycle();
        start = 0;
        while (m_cnt != 41 && cyc < 400) begin
            cycle();
            cyc++;
        end
        lap = 1;
        cycle();
        lap = 0;
        n_cmp++;
        if (disp_value !== 16'h0041 || lap_active !== 1'b1) begin
            n_bad++;
            $display("FAIL lap_capture got %h/%b exp 0041/1", disp_value, lap_active);
        end
        cyc = 0;
        while (m_lt != 0 && cyc < 40) begin
            cycle();
            cyc++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL lap_hold cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
        end
        cycle();
        n_cmp++;
        if (disp_value !== count || count !== 16'h0044) begin
            n_bad++;
            $display("FAIL lap_release got disp=%h count=%h exp 0044/0044", disp_value, count);
        end
    endtask

    task automatic test_priority();
        start = 1; stop = 1;
        cycle();
        start = 0; stop = 0;
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL start_stop got %b exp 0", running);
        end
        clear = 1; load = 1; preset = 16'h1234;
        cycle();
        clear = 0;
        n_cmp++;
        if (count !== 16'h0000) begin
            n_bad++;
            $display("FAIL clear_load got %h exp 0000", count);
        end
        preset = 16'hA5F3;
        cycle();
        load = 0;
        n_cmp++;
        if (count !== 16'h9593 || wrap !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_clamp got %h w%b d%b exp 9593 w0 d0", count, wrap, done);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            start  = ($urandom % 6) == 0;
            stop   = ($urandom % 25) == 0;
            lap    = ($urandom % 30) == 0;
            clear  = ($urandom % 90) == 0;
            load   = ($urandom % 40) == 0;
            preset = 16'($urandom);
            if (($urandom % 60) == 0) down = ~down;
            cycle();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
        end
        {start, stop, lap, clear, load, down} = '0;
    endtask

    task automatic test_reset_mid();
        load = 1; preset = 16'h9999;
        cycle();
        load = 0; start = 1;
        cycle();
        start = 0; lap = 1;
        cycle();
        lap = 0;
        repeat (2) cycle();
        #2 RST = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_async got %h exp 0", dut_vec());
        end
        repeat (4) begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec() !== 37'd0) begin
                n_bad++;
                $display("FAIL reset_held got %h exp 0", dut_vec());
            end
        end
        RST = 1'b0;
        repeat (6) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL after_reset got %h exp %h", dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_wrap();
        test_down();
        test_lap();
        test_priority();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
